// File: rtl/hwpe_ctrl_package.sv
// hwpe_ctrl_package: shared HWPE control types, microcode structure and loader constants
// Contents: UCODE_* sizing constants, ucode_code_t / ucode_loop_t / ucode_t,
//           loader word counts (UCODE_LDR_*) and the loader FSM state type.
package hwpe_ctrl_package;

    localparam int UCODE_LENGTH    = 16;
    localparam int UCODE_NB_LOOPS  = 6;
    localparam int UCODE_NB_REG    = 4;
    localparam int UCODE_NB_RO_REG = 28;
    localparam int UCODE_CNT_WIDTH = 12;
    localparam int UCODE_A_W       = $clog2(UCODE_NB_REG);
    localparam int UCODE_B_W       = $clog2(UCODE_NB_REG + UCODE_NB_RO_REG);

    // Field order gives byte layout [0] op_sel, [2:1] a, [7:3] b
    typedef struct packed {
        logic [UCODE_B_W-1:0] b;
        logic [UCODE_A_W-1:0] a;
        logic                 op_sel;
    } ucode_code_t;

    // Field order gives byte layout [3:0] ucode_addr, [6:4] nb_ops
    typedef struct packed {
        logic [2:0]                      nb_ops;
        logic [$clog2(UCODE_LENGTH)-1:0] ucode_addr;
    } ucode_loop_t;

    typedef struct packed {
        ucode_code_t [UCODE_LENGTH-1:0]                        code;
        ucode_loop_t [UCODE_NB_LOOPS-1:0]                      loops;
        logic        [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] range;
    } ucode_t;

    localparam int UCODE_LDR_NC     = (UCODE_LENGTH * 8 + 31) / 32;
    localparam int UCODE_LDR_NL     = (UCODE_NB_LOOPS + 3) / 4;
    localparam int UCODE_LDR_NWORDS = UCODE_LDR_NC + UCODE_LDR_NL + UCODE_NB_LOOPS;
    localparam int UCODE_LDR_CNT_W  = $clog2(UCODE_LDR_NWORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LD_CODE,
        LD_LOOP,
        LD_RANGE,
        COMMIT
    } ucode_ldr_state_t;

endpackage

// File: rtl/hwpe_ctrl_ucode_loader_check.sv
// hwpe_ctrl_ucode_loader_check: combinational validity check of one accepted loader word
// Ports: word_i  packed configuration word
//        state_i loader state (selects loop or range rules)
//        cnt_i   global word index, locates which loop bytes are real
//        err_o   word violates a loop or range rule
// Used only when HWPE_UCODE_LOADER_CHECK_EN is defined.
module hwpe_ctrl_ucode_loader_check
    import hwpe_ctrl_package::*;
(
    input  logic [31:0]                word_i,
    input  ucode_ldr_state_t           state_i,
    input  logic [UCODE_LDR_CNT_W-1:0] cnt_i,
    output logic                       err_o
);

    ucode_loop_t lp;

    always_comb begin
        lp    = '0;
        err_o = (state_i == LD_RANGE) && (word_i[UCODE_CNT_WIDTH-1:0] == '0);
        for (int b = 0; b < 4; b++) begin
            lp = ucode_loop_t'(word_i[8*b +: 7]);
            // trailing bytes past the last loop descriptor are padding
            if (state_i == LD_LOOP && (int'(cnt_i) - UCODE_LDR_NC) * 4 + b < UCODE_NB_LOOPS)
                err_o = err_o | word_i[8*b+7] | (lp.nb_ops == '0) |
                        (({1'b0, lp.ucode_addr} + {2'b00, lp.nb_ops}) > 5'(UCODE_LENGTH));
        end
    end

endmodule

// File: rtl/hwpe_ctrl_ucode_loader.sv
// hwpe_ctrl_ucode_loader: double-buffered microcode writer fed by a 32-bit word stream
// Ports: clk_i, rst_ni (async active-low), test_mode_i (unused), clear_i (sync soft clear)
//        start_i begin/restart a load; word_i/valid_i/ready_o word handshake
//        ucode_o committed program; ucode_valid_o program committed
//        busy_o load in progress; done_o end-of-load pulse; error_o last load rejected
// Macro HWPE_UCODE_LOADER_CHECK_EN enables per-word checks; otherwise every load commits.
module hwpe_ctrl_ucode_loader
    import hwpe_ctrl_package::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        test_mode_i,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic [31:0] word_i,
    input  logic        valid_i,
    output logic        ready_o,
    output ucode_t      ucode_o,
    output logic        ucode_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int CI_W = $clog2(UCODE_LENGTH);
    localparam int LI_W = $clog2(UCODE_NB_LOOPS);
    localparam logic [UCODE_LDR_CNT_W-1:0] CODE_END  = UCODE_LDR_CNT_W'(UCODE_LDR_NC - 1);
    localparam logic [UCODE_LDR_CNT_W-1:0] LOOP_END  = UCODE_LDR_CNT_W'(UCODE_LDR_NC + UCODE_LDR_NL - 1);
    localparam logic [UCODE_LDR_CNT_W-1:0] RANGE_END = UCODE_LDR_CNT_W'(UCODE_LDR_NWORDS - 1);

    ucode_ldr_state_t           state;
    logic [UCODE_LDR_CNT_W-1:0] cnt;
    ucode_t                     shadow;
    logic                       err_q;
    logic                       word_err;
    logic                       acc;
    logic                       unused_test_mode;

    assign unused_test_mode = test_mode_i;
    assign ready_o = (state == LD_CODE) || (state == LD_LOOP) || (state == LD_RANGE);
    assign busy_o  = state != IDLE;
    assign acc     = valid_i & ready_o;

`ifdef HWPE_UCODE_LOADER_CHECK_EN
    hwpe_ctrl_ucode_loader_check i_check (
        .word_i  (word_i),
        .state_i (state),
        .cnt_i   (cnt),
        .err_o   (word_err)
    );
`else
    assign word_err = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            shadow        <= '0;
            err_q         <= 1'b0;
            ucode_o       <= '0;
            ucode_valid_o <= 1'b0;
            error_o       <= 1'b0;
            done_o        <= 1'b0;
        end else if (clear_i) begin
            state         <= IDLE;
            cnt           <= '0;
            shadow        <= '0;
            err_q         <= 1'b0;
            ucode_o       <= '0;
            ucode_valid_o <= 1'b0;
            error_o       <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i && state != COMMIT) begin
                // a start mid-load drops the partial shadow; the word on this cycle is discarded
                state         <= LD_CODE;
                cnt           <= '0;
                shadow        <= '0;
                err_q         <= 1'b0;
                ucode_valid_o <= 1'b0;
                error_o       <= 1'b0;
            end else if (state == COMMIT) begin
                if (!err_q) begin
                    ucode_o       <= shadow;
                    ucode_valid_o <= 1'b1;
                end
                error_o <= err_q;
                state   <= IDLE;
            end else if (acc) begin
                cnt    <= cnt + 1'b1;
                err_q  <= err_q | word_err;
                done_o <= (state == LD_RANGE) && (cnt == RANGE_END);
                state  <= (state == LD_CODE  && cnt == CODE_END)  ? LD_LOOP  :
                          (state == LD_LOOP  && cnt == LOOP_END)  ? LD_RANGE :
                          (state == LD_RANGE && cnt == RANGE_END) ? COMMIT   : state;
                for (int b = 0; b < 4; b++) begin
                    if (state == LD_CODE)
                        shadow.code[CI_W'(int'(cnt) * 4 + b)] <= ucode_code_t'(word_i[8*b +: 8]);
                    if (state == LD_LOOP && (int'(cnt) - UCODE_LDR_NC) * 4 + b < UCODE_NB_LOOPS)
                        shadow.loops[LI_W'((int'(cnt) - UCODE_LDR_NC) * 4 + b)] <= ucode_loop_t'(word_i[8*b +: 7]);
                end
                if (state == LD_RANGE)
                    shadow.range[LI_W'(int'(cnt) - UCODE_LDR_NC - UCODE_LDR_NL)] <= word_i[UCODE_CNT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/hwpe_ctrl_ucode_loader.md
Name: hwpe_ctrl_ucode_loader

Overview:
- Writer side of the HWPE microcode interface. Consumes a stream of packed 32-bit configuration words from the slave/register-file path, decodes them into the shared `ucode_t` structure, and commits the result atomically.
- The committed `ucode_o` drives the `ucode_i` input of the microcode sequencer.
- Double-buffered: the previously committed program stays stable on `ucode_o` while a new one loads.

Parameters:
- LENGTH, 16, number of microcode instructions
- NB_LOOPS, 6, number of loop descriptors
- NB_REG, 4, sequencer read/write registers; A_W = $clog2(NB_REG) = 2
- NB_RO_REG, 28, sequencer read-only registers; B_W = $clog2(NB_REG+NB_RO_REG) = 5
- CNT_WIDTH, 12, width of the loop range field
- All must match the `hwpe_ctrl_package` UCODE_* values that size `ucode_t`.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- test_mode_i  in  1  unused; kept for interface uniformity
- clear_i  in  1  synchronous soft clear
- start_i  in  1  begin or restart a program load
- word_i  in  32  packed configuration word
- valid_i  in  1  word_i valid
- ready_o  out  1  loader accepts a word
- ucode_o  out  ucode_t  committed microcode (code, loops, range)
- ucode_valid_o  out  1  ucode_o holds a complete, committed program
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse when a load finishes (commit or error)
- error_o  out  1  sticky: last load was rejected

Behaviour:
- Handshake: a word is accepted when valid_i & ready_o. ready_o is high only in the LD_* states. ready_o does not depend combinationally on valid_i.
- Word order (12 words at defaults):
  - Code words: NC = ceil(LENGTH*8/32) = 4. Instruction i is byte i%4 of word i/4. Byte layout: [0] op_sel, [2:1] a, [7:3] b.
  - Loop words: NL = ceil(NB_LOOPS/4) = 2. Loop j is byte j%4 of word j/4. Byte layout: [3:0] ucode_addr, [6:4] nb_ops, [7] reserved.
  - Range words: NB_LOOPS words. range[k] = word[CNT_WIDTH-1:0]; upper bits are ignored.
  - Unused trailing bytes of the last code/loop word are ignored.
- FSM states: IDLE, LD_CODE, LD_LOOP, LD_RANGE, COMMIT. A single word counter is used; its width covers NC+NL+NB_LOOPS.
  - IDLE: on start_i, go to LD_CODE, counter=0, error_o=0, ucode_valid_o=0.
  - LD_CODE: after NC accepted words, go to LD_LOOP.
  - LD_LOOP: after NL accepted words, go to LD_RANGE.
  - LD_RANGE: after NB_LOOPS accepted words, go to COMMIT.
  - COMMIT (one cycle): if no error, copy shadow to ucode_o and set ucode_valid_o=1. In all cases pulse done_o, then go to IDLE.
- Latency: ucode_o and ucode_valid_o update on the clock edge one cycle after the final handshake. done_o is high during that COMMIT cycle.
- Each accepted word is written into the shadow register only; ucode_o never changes mid-load.
- busy_o = 1 in every state except IDLE.
- start_i during LD_*: restart at LD_CODE with counter=0; the partial shadow is discarded. ucode_o keeps its old value; ucode_valid_o stays 0.
- start_i in COMMIT: ignored.
- clear_i (priority over start_i): return to IDLE. ucode_o, shadow, counter, ucode_valid_o, error_o and done_o are all zeroed.
- Reset values: state=IDLE, every output 0, shadow=0.
- Gaps in valid_i are allowed at any point; the counter holds while valid_i is low.

Optional Feature:
- Macro: HWPE_UCODE_LOADER_CHECK_EN.
- When defined, each accepted word is checked. The checks are:
  - a loop byte with reserved bit 7 = 1;
  - nb_ops = 0;
  - ucode_addr + nb_ops > LENGTH (compare using a 5-bit sum);
  - range = 0.
- A failed check sets an internal error flag. The load still consumes all remaining words so the stream stays aligned. COMMIT then skips the copy, leaves ucode_valid_o=0, and sets error_o=1.
- When undefined, no checks are performed, error_o is tied to 0, and every load commits.

Decomposition:
- Add to `hwpe_ctrl_package`: UCODE_LDR_NC, UCODE_LDR_NL and UCODE_LDR_NWORDS, plus a `ucode_ldr_state_t` enum.
- `ucode_t`, `ucode_code_t` and `ucode_loop_t` already exist there and are reused unchanged.
- Sub-module: hwpe_ctrl_ucode_loader_check, purely combinational. Inputs: word_i and the current state. Output: a per-word error flag. It is instantiated only under the macro.

Test Plan:
- Reset: hold rst_ni=0, then release with no other stimulus → ready_o=0, busy_o=0, ucode_valid_o=0, ucode_o=0.
- Full load, valid_i held high, word1=0x0000F900, loop word0=0x00000030, range words = 3 → 12 accepts in 12 cycles. One cycle after the last accept: code[5] = {op_sel=1, a=0, b=31}; loops[0] = {addr=0, nb_ops=3}; range[k]=3; ucode_valid_o=1; done_o pulses once.
- Same load with valid_i low on every other cycle → identical ucode_o. busy_o stays 1 for the whole load. ucode_o is unchanged until the commit.
- Restart: after a committed program P, pulse start_i, send 7 words, pulse start_i again, then send full program Q → ucode_o equals P until Q commits. ucode_valid_o stays 0 until the Q commit.
- clear_i after 5 words → next cycle state=IDLE, ready_o=0, ucode_o=0, no done_o pulse.
- CHECK_EN, loop byte 0x7E (addr=14, nb_ops=7, 14+7 > 16) → all 12 words still accepted. done_o pulses, error_o=1, ucode_valid_o=0, ucode_o keeps its prior value.
